// File: rtl/down_timer_if.sv
// Control/status bundle for the loadable down-timer.
// The master side loads and commands the timer; the slave side is the timer itself.
interface down_timer_if #(
    parameter int WIDTH = 8
);
    logic             ld;
    logic [WIDTH-1:0] in;
    logic             start;
    logic             stop;
    logic             dec;
    logic             auto_rl;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output ld, in, start, stop, dec, auto_rl,
        input  out, tc, busy, done
    );

    modport slave (
        input  ld, in, start, stop, dec, auto_rl,
        output out, tc, busy, done
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counter with sticky DONE, one-cycle terminal-count pulse and
// optional auto-reload, for pacing datapath stages.
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    down_timer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_nx;
    logic [WIDTH-1:0] out_q, out_nx;
    logic [WIDTH-1:0] rl_q, rl_nx;
    logic             tc_q, tc_nx;
    logic             busy_c, done_c;

    // State and datapath registers; reset clears everything, so no tc escapes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            rl_q    <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_nx;
            out_q   <= out_nx;
            rl_q    <= rl_nx;
            tc_q    <= tc_nx;
        end
    end

    // Next state: ld > stop > start > dec. A command that has no effect in
    // the current state (stop outside RUN, start in RUN) does not block the
    // lower-priority ones.
    always_comb begin
        state_nx = state_q;
        out_nx   = out_q;
        rl_nx    = rl_q;
        tc_nx    = 1'b0;
        if (bus.ld) begin
            out_nx   = bus.in;
            rl_nx    = bus.in;
            state_nx = IDLE;
        end else if (bus.stop && state_q == RUN) begin
            state_nx = IDLE;
        end else if (bus.start && state_q == IDLE) begin
            if (out_q != '0) begin
                state_nx = RUN;
            end else begin
                state_nx = DONE;
                tc_nx    = 1'b1;
            end
        end else if (bus.start && state_q == DONE) begin
            if (rl_q != '0) begin
                out_nx   = rl_q;
                state_nx = RUN;
            end else begin
                tc_nx    = 1'b1;
            end
        end else if (bus.dec && state_q == RUN) begin
            if (out_q > WIDTH'(1)) begin
                out_nx = out_q - WIDTH'(1);
            end else if (out_q == WIDTH'(1)) begin
                tc_nx = 1'b1;
                if (bus.auto_rl) begin
                    out_nx = rl_q;
                end else begin
                    out_nx   = '0;
                    state_nx = DONE;
                end
            end
            // out_q==0 cannot occur in RUN; holding guards against underflow.
        end
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state_q)
            RUN:     busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.out  = out_q;
    assign bus.tc   = tc_q;
    assign bus.busy = busy_c;
    assign bus.done = done_c;
endmodule
